// File: rtl/hazard_unit.sv
// hazard_unit -- pipeline hazard controller for the PMIPS 16-bit datapath.
//
// Keeps a DEPTH-entry shift scoreboard of in-flight destination registers,
// detects read-after-write hazards for the instruction in IF/ID, holds fetch
// for BR_LAT cycles behind each issued beq and counts stall cycles.
//
// Optional feature macro: HAZARD_FWD_EN
//   defined   : non-load hazards are forwarded (fwd_a/fwd_b pick the youngest
//               matching entry); only a load in entry 1 stalls (load-use).
//   undefined : fwd_a/fwd_b stay 0 and every hazard stalls.
//
// Parameters:
//   DEPTH   in-flight stages tracked after ID (1..7)
//   REG_AW  register-address width
//   BR_LAT  fetch-hold cycles after a beq issues (0..7)
// Ports:
//   clock          rising-edge clock
//   reset          synchronous, active-high
//   instr_id       IF/ID instruction {opcode,rs,rt,rd,funct}
//   pc_stall       hold PC and IF/ID
//   idex_bubble    load zero into ID/EX instead of the decoded instruction
//   branch_pending branch hold counter is non-zero
//   fwd_a, fwd_b   forwarding select for rs / rt (0 = register file)
//   stall_count    saturating count of pc_stall cycles since reset

module hazard_unit #(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 3,
    parameter int BR_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instr_id,
    output logic        pc_stall,
    output logic        idex_bubble,
    output logic        branch_pending,
    output logic [2:0]  fwd_a,
    output logic [2:0]  fwd_b,
    output logic [15:0] stall_count
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dest;
        logic              is_load;
    } sb_entry_t;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_BEQ   = 3'd2;
    localparam logic [2:0] OP_ADDI  = 3'd3;
    localparam logic [2:0] OP_LW    = 3'd5;
    localparam logic [2:0] OP_SW    = 3'd6;

    sb_entry_t sb [1:DEPTH];
    logic [2:0] br_cnt;

    logic [2:0]        opcode;
    logic [REG_AW-1:0] rs, rt, rd;
    logic [3:0]        funct_unused;

    assign opcode       = instr_id[15:13];
    assign rs           = REG_AW'(instr_id[12:10]);
    assign rt           = REG_AW'(instr_id[9:7]);
    assign rd           = REG_AW'(instr_id[6:4]);
    assign funct_unused = instr_id[3:0];

    // ---------------------------------------------------------------- decode
    logic              src_a_vld, src_b_vld, dst_vld, dst_load, is_beq;
    logic [REG_AW-1:0] dst;

    always_comb begin
        src_a_vld = 1'b0;
        src_b_vld = 1'b0;
        dst_vld   = 1'b0;
        dst_load  = 1'b0;
        dst       = rd;
        unique case (opcode)
            OP_RTYPE: begin src_a_vld = 1'b1; src_b_vld = 1'b1; dst_vld = 1'b1; dst = rd; end
            OP_ADDI:  begin src_a_vld = 1'b1; dst_vld = 1'b1; dst = rt; end
            OP_LW:    begin src_a_vld = 1'b1; dst_vld = 1'b1; dst = rt; dst_load = 1'b1; end
            OP_SW,
            OP_BEQ:   begin src_a_vld = 1'b1; src_b_vld = 1'b1; end
            default:  ;
        endcase
        // r0 is hard-wired zero: never a source, never tracked
        if (rs == '0)  src_a_vld = 1'b0;
        if (rt == '0)  src_b_vld = 1'b0;
        if (dst == '0) dst_vld   = 1'b0;
    end

    assign is_beq = (opcode == OP_BEQ);

    // ------------------------------------------------------- scoreboard match
    // Scan oldest to youngest so the youngest (lowest-numbered) match wins.
    logic       hit_a, hit_b, load_a, load_b;
    logic [2:0] sel_a, sel_b;

    always_comb begin
        hit_a = 1'b0; hit_b = 1'b0;
        load_a = 1'b0; load_b = 1'b0;
        sel_a = '0;   sel_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (src_a_vld && sb[k].valid && sb[k].dest == rs) begin
                hit_a  = 1'b1;
                sel_a  = 3'(k);
                load_a = sb[k].is_load;
            end
            if (src_b_vld && sb[k].valid && sb[k].dest == rt) begin
                hit_b  = 1'b1;
                sel_b  = 3'(k);
                load_b = sb[k].is_load;
            end
        end
    end

    logic raw_stall, br_hold;

`ifdef HAZARD_FWD_EN
    // Only a load that has not yet reached MEM/WB cannot be forwarded.
    assign raw_stall = (hit_a && load_a && sel_a == 3'd1) ||
                       (hit_b && load_b && sel_b == 3'd1);
`else
    assign raw_stall = hit_a || hit_b;
`endif

    assign br_hold        = (br_cnt != '0) && !reset;
    assign branch_pending = br_hold;
    assign pc_stall       = reset || raw_stall || br_hold;
    assign idex_bubble    = pc_stall;

`ifdef HAZARD_FWD_EN
    // Selects are only meaningful for an instruction that actually issues.
    assign fwd_a = pc_stall ? 3'd0 : sel_a;
    assign fwd_b = pc_stall ? 3'd0 : sel_b;
`else
    assign fwd_a = 3'd0;
    assign fwd_b = 3'd0;
`endif

    // ------------------------------------------------------------ sequential
    logic issue;
    assign issue = !idex_bubble;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
            br_cnt      <= '0;
            stall_count <= '0;
        end else begin
            sb[1] <= (issue && dst_vld) ? '{valid: 1'b1, dest: dst, is_load: dst_load}
                                        : '0;
            for (int k = 2; k <= DEPTH; k++) sb[k] <= sb[k-1];

            // A RAW-stalled beq loads the counter only once it issues.
            if (issue && is_beq)
                br_cnt <= 3'(BR_LAT);
            else if (br_cnt != '0)
                br_cnt <= br_cnt - 3'd1;

            if (pc_stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: the stimulus process pushes the expected
// output vector for every cycle it drives; a monitor pops and compares on the
// falling edge. Expectations follow the default build or HAZARD_FWD_EN.
module tb_hazard_unit;

    logic        clock;
    logic        reset;
    logic [15:0] instr_id;
    logic        pc_stall, idex_bubble, branch_pending;
    logic [2:0]  fwd_a, fwd_b;
    logic [15:0] stall_count;

    hazard_unit #(.DEPTH(3), .REG_AW(3), .BR_LAT(2)) dut (
        .clock(clock), .reset(reset), .instr_id(instr_id),
        .pc_stall(pc_stall), .idex_bubble(idex_bubble),
        .branch_pending(branch_pending), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          tag;
        logic        st;
        logic        pend;
        logic [2:0]  fa;
        logic [2:0]  fb;
        logic [15:0] sc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad   = 0;
    int          step  = 0;
    logic [15:0] exp_sc = 16'd0;

    task automatic chk(input string nm, input int tag, input logic [15:0] got,
                       input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, tag, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("pc_stall",       e.tag, 16'(pc_stall),       16'(e.st));
            chk("idex_bubble",    e.tag, 16'(idex_bubble),    16'(e.st));
            chk("branch_pending", e.tag, 16'(branch_pending), 16'(e.pend));
            chk("fwd_a",          e.tag, 16'(fwd_a),          16'(e.fa));
            chk("fwd_b",          e.tag, 16'(fwd_b),          16'(e.fb));
            chk("stall_count",    e.tag, stall_count,         e.sc);
        end
    end

    // Drive one cycle and queue the outputs expected during it.
    task automatic cyc(input logic rst, input logic [15:0] ins, input logic st,
                       input logic pend, input logic [2:0] fa, input logic [2:0] fb);
        exp_t e;
        reset    = rst;
        instr_id = ins;
        e.tag = step; e.st = st; e.pend = pend; e.fa = fa; e.fb = fb; e.sc = exp_sc;
        q.push_back(e);
        step++;
        @(posedge clock); #1;
        if (rst) exp_sc = 16'd0;
        else if (st && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
    endtask

    task automatic flush();
        repeat (3) cyc(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0);
    endtask

    initial begin
        reset = 1'b1;
        instr_id = 16'h0000;
        @(posedge clock); #1;

        // reset held two cycles, then first cycle after release never stalls
        cyc(1'b1, 16'h04A3, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b1, 16'h04A3, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h04A3, 1'b0, 1'b0, 3'd0, 3'd0);
        flush();

        // addi r1,r0,5 ; add r2,r1,r1
        cyc(1'b0, 16'h6085, 1'b0, 1'b0, 3'd0, 3'd0);
`ifdef HAZARD_FWD_EN
        cyc(1'b0, 16'h04A3, 1'b0, 1'b0, 3'd1, 3'd1);
`else
        repeat (3) cyc(1'b0, 16'h04A3, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h04A3, 1'b0, 1'b0, 3'd0, 3'd0);
`endif
        flush();

        // lw r3,0(r1) ; add r4,r3,r0
        cyc(1'b0, 16'hA580, 1'b0, 1'b0, 3'd0, 3'd0);
`ifdef HAZARD_FWD_EN
        cyc(1'b0, 16'h0C43, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h0C43, 1'b0, 1'b0, 3'd2, 3'd0);
`else
        repeat (3) cyc(1'b0, 16'h0C43, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h0C43, 1'b0, 1'b0, 3'd0, 3'd0);
`endif
        flush();

        // beq r1,r2 on an empty scoreboard: two hold cycles
        cyc(1'b0, 16'h4501, 1'b0, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0);

        // writes to r0 and reads of r0 never stall
        cyc(1'b0, 16'h6005, 1'b0, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h0003, 1'b0, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0);

        // beq that depends on the previous addi: hazard first, then hold
        cyc(1'b0, 16'h6085, 1'b0, 1'b0, 3'd0, 3'd0);
`ifdef HAZARD_FWD_EN
        cyc(1'b0, 16'h4501, 1'b0, 1'b0, 3'd1, 3'd0);
`else
        repeat (3) cyc(1'b0, 16'h4501, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h4501, 1'b0, 1'b0, 3'd0, 3'd0);
`endif
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd0);
        cyc(1'b0, 16'h0000, 1'b1, 1'b1, 3'd0, 3'd0);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 3'd0);

        // reset mid-operation wipes the scoreboard and the stall counter
        cyc(1'b0, 16'h6085, 1'b0, 1'b0, 3'd0, 3'd0);
        cyc(1'b1, 16'h04A3, 1'b1, 1'b0, 3'd0, 3'd0);
        cyc(1'b0, 16'h04A3, 1'b0, 1'b0, 3'd0, 3'd0);
        flush();

        repeat (2) @(posedge clock);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
